period_meter: RTL and testbench

PERIOD_METER -- requirements
Module: period_meter

---
 rtl/period_meter.sv | 151 +++++++++++++++
 tb/tb_period_meter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/period_meter.sv
// Period meter: measures the rising-to-rising period and high time of a slow,
// asynchronous input clock in units of CLK_IN cycles.
//
// Ports:
//   CLK_IN    in   system clock, sole clock domain
//   RST       in   synchronous active-high reset
//   EN        in   measurement enable
//   SIG_IN    in   slow clock to be measured (asynchronous)
//   PERIOD    out  last completed rising-to-rising period, in CLK_IN cycles
//   HIGH_TIME out  high time of that same period, in CLK_IN cycles
//   VALID     out  one-cycle pulse when PERIOD/HIGH_TIME update
//   TIMEOUT   out  sticky flag, set when a measurement is abandoned
//   State     out  FSM state: 00 WAIT, 01 HIGH, 10 LOW, 11 TMO
module period_meter #(
  parameter logic [31:0] TIMEOUT_LIMIT = 32'd100000000
) (
  input  logic        CLK_IN,
  input  logic        RST,
  input  logic        EN,
  input  logic        SIG_IN,
  output logic [31:0] PERIOD,
  output logic [31:0] HIGH_TIME,
  output logic        VALID,
  output logic        TIMEOUT,
  output logic [1:0]  State
);

  typedef enum logic [1:0] {
    StWait = 2'b00,
    StHigh = 2'b01,
    StLow  = 2'b10,
    StTmo  = 2'b11
  } state_e;

  // Synchronizer and edge-detect register; these keep sampling while EN is low
  // so that re-enabling never sees a stale level as a fresh edge.
  logic sync1_q, sync2_q, sig_prev_q;
  logic rise, fall;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] cnt_inc;
  logic [31:0] hi_pend_q, hi_pend_d;
  logic [31:0] period_q, period_d;
  logic [31:0] high_time_q, high_time_d;
  logic        valid_q, valid_d;
  logic        timeout_q, timeout_d;
  logic        at_limit;

  assign rise     = sync2_q & ~sig_prev_q;
  assign fall     = ~sync2_q & sig_prev_q;
  assign at_limit = (cnt_q == TIMEOUT_LIMIT);
  // Counter saturates at the limit so a stalled input cannot wrap it.
  assign cnt_inc  = at_limit ? cnt_q : cnt_q + 32'd1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_pend_d   = hi_pend_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    valid_d     = 1'b0;
    timeout_d   = timeout_q;

    if (!EN) begin
      state_d   = StWait;
      cnt_d     = '0;
      hi_pend_d = '0;
    end else begin
      case (state_q)
        StWait: begin
          if (rise) begin
            state_d = StHigh;
            cnt_d   = 32'd1;
          end
        end
        StHigh: begin
          if (rise) begin
            // Cannot happen with a clean synchronizer; restart as a first edge.
            cnt_d = 32'd1;
          end else if (fall) begin
            hi_pend_d = cnt_q;
            cnt_d     = cnt_inc;
            state_d   = StLow;
          end else if (at_limit) begin
            state_d   = StTmo;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        StLow: begin
          // An edge coinciding with the limit wins over the timeout.
          if (rise) begin
            period_d    = cnt_q;
            high_time_d = hi_pend_q;
            valid_d     = 1'b1;
            cnt_d       = 32'd1;
            state_d     = StHigh;
          end else if (at_limit) begin
            state_d   = StTmo;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        StTmo: begin
          if (rise) begin
            state_d   = StHigh;
            cnt_d     = 32'd1;
            timeout_d = 1'b0;
          end
        end
        default: state_d = StWait;
      endcase
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sig_prev_q  <= 1'b0;
      state_q     <= StWait;
      cnt_q       <= '0;
      hi_pend_q   <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      sync1_q     <= SIG_IN;
      sync2_q     <= sync1_q;
      sig_prev_q  <= sync2_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_pend_q   <= hi_pend_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign PERIOD    = period_q;
  assign HIGH_TIME = high_time_q;
  assign VALID     = valid_q;
  assign TIMEOUT   = timeout_q;
  assign State     = state_q;

endmodule

// File: tb/tb_period_meter.sv
module tb_period_meter;

  logic        CLK_IN = 1'b0;
  logic        RST;
  logic        EN;
  logic        SIG_IN;
  logic [31:0] PERIOD;
  logic [31:0] HIGH_TIME;
  logic        VALID;
  logic        TIMEOUT;
  logic [1:0]  State;

  typedef struct packed {
    logic [31:0] per;
    logic [31:0] ht;
  } rep_t;

  rep_t rep_q[$];
  int   rep_cyc[$];
  int   cyc = 0;
  logic prev_valid = 1'b0;
  logic dbl_valid = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   rise_cyc;

  period_meter #(.TIMEOUT_LIMIT(32'd1000)) dut (
    .CLK_IN   (CLK_IN),
    .RST      (RST),
    .EN       (EN),
    .SIG_IN   (SIG_IN),
    .PERIOD   (PERIOD),
    .HIGH_TIME(HIGH_TIME),
    .VALID    (VALID),
    .TIMEOUT  (TIMEOUT),
    .State    (State)
  );

  always #5 CLK_IN = ~CLK_IN;

  // Report collector: records every VALID pulse with its cycle number.
  initial begin
    forever begin
      @(negedge CLK_IN);
      cyc = cyc + 1;
      if (VALID) begin
        rep_q.push_back({PERIOD, HIGH_TIME});
        rep_cyc.push_back(cyc);
      end
      if (VALID && prev_valid) dbl_valid = 1'b1;
      prev_valid = VALID;
    end
  end

  // Drive SIG_IN to lvl for exactly n cycles, changing 1 time unit after a posedge.
  task automatic hold(input logic lvl, input int n);
    SIG_IN = lvl;
    repeat (n) begin
      @(posedge CLK_IN);
      #1;
    end
  endtask

  task automatic clear_reports();
    rep_q.delete();
    rep_cyc.delete();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    EN = 1'b1;
    SIG_IN = 1'b0;
    repeat (3) @(posedge CLK_IN);
    @(negedge CLK_IN);
    vectors++; if (State !== 2'b00) begin miscompares++;
      $display("FAIL reset_state got %b want 00", State); end
    vectors++; if (PERIOD !== 32'd0) begin miscompares++;
      $display("FAIL reset_period got %0d want 0", PERIOD); end
    vectors++; if (HIGH_TIME !== 32'd0) begin miscompares++;
      $display("FAIL reset_high_time got %0d want 0", HIGH_TIME); end
    vectors++; if (VALID !== 1'b0) begin miscompares++;
      $display("FAIL reset_valid got %b want 0", VALID); end
    vectors++; if (TIMEOUT !== 1'b0) begin miscompares++;
      $display("FAIL reset_timeout got %b want 0", TIMEOUT); end
    @(posedge CLK_IN);
    #1;
    RST = 1'b0;
  endtask

  // 100-cycle period, 40 high: first report after the 2nd rise, then every 100 cycles.
  task automatic test_basic();
    clear_reports();
    rise_cyc = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 1) rise_cyc = cyc;
      hold(1'b1, 40);
      hold(1'b0, 60);
    end
    vectors++; if (rep_q.size() !== 5) begin miscompares++;
      $display("FAIL basic_count got %0d want 5", rep_q.size()); end
    if (rep_q.size() > 0) begin
      vectors++; if (rep_cyc[0] !== rise_cyc + 4) begin miscompares++;
        $display("FAIL basic_first_cycle got %0d want %0d", rep_cyc[0], rise_cyc + 4); end
    end
    for (int i = 0; i < rep_q.size(); i++) begin
      vectors++; if (rep_q[i].per !== 32'd100) begin miscompares++;
        $display("FAIL basic_period[%0d] got %0d want 100", i, rep_q[i].per); end
      vectors++; if (rep_q[i].ht !== 32'd40) begin miscompares++;
        $display("FAIL basic_high_time[%0d] got %0d want 40", i, rep_q[i].ht); end
      if (i > 0) begin
        vectors++; if (rep_cyc[i] - rep_cyc[i-1] !== 100) begin miscompares++;
          $display("FAIL basic_spacing[%0d] got %0d want 100", i, rep_cyc[i] - rep_cyc[i-1]); end
      end
    end
  endtask

  // Switch 100/40 -> 250/125 via one mixed period (40 high, 210 low).
  task automatic test_period_change();
    rep_t exp [4];
    exp[0] = {32'd100, 32'd40};
    exp[1] = {32'd250, 32'd40};
    exp[2] = {32'd250, 32'd125};
    exp[3] = {32'd250, 32'd125};
    clear_reports();
    hold(1'b1, 40);
    hold(1'b0, 210);
    for (int i = 0; i < 3; i++) begin
      hold(1'b1, 125);
      hold(1'b0, 125);
    end
    vectors++; if (rep_q.size() !== 4) begin miscompares++;
      $display("FAIL change_count got %0d want 4", rep_q.size()); end
    for (int i = 0; i < rep_q.size() && i < 4; i++) begin
      vectors++; if (rep_q[i] !== exp[i]) begin miscompares++;
        $display("FAIL change_report[%0d] got %0d/%0d want %0d/%0d", i,
                 rep_q[i].per, rep_q[i].ht, exp[i].per, exp[i].ht); end
    end
  endtask

  // Stuck-high input: TMO exactly 1000 cycles after entering HIGH.
  task automatic test_timeout();
    clear_reports();
    SIG_IN = 1'b1;
    repeat (3) @(posedge CLK_IN);
    @(negedge CLK_IN);
    vectors++; if (State !== 2'b01) begin miscompares++;
      $display("FAIL tmo_enter_high got %b want 01", State); end
    repeat (999) @(posedge CLK_IN);
    @(negedge CLK_IN);
    vectors++; if (State !== 2'b01) begin miscompares++;
      $display("FAIL tmo_before_limit got %b want 01", State); end
    vectors++; if (TIMEOUT !== 1'b0) begin miscompares++;
      $display("FAIL tmo_flag_early got %b want 0", TIMEOUT); end
    @(posedge CLK_IN);
    @(negedge CLK_IN);
    vectors++; if (State !== 2'b11) begin miscompares++;
      $display("FAIL tmo_state got %b want 11", State); end
    vectors++; if (TIMEOUT !== 1'b1) begin miscompares++;
      $display("FAIL tmo_flag got %b want 1", TIMEOUT); end
    vectors++; if (PERIOD !== 32'd250 || HIGH_TIME !== 32'd125) begin miscompares++;
      $display("FAIL tmo_hold got %0d/%0d want 250/125", PERIOD, HIGH_TIME); end
    vectors++; if (rep_q.size() !== 1) begin miscompares++;
      $display("FAIL tmo_reports got %0d want 1", rep_q.size()); end
    @(posedge CLK_IN);
    #1;
    hold(1'b0, 20);
    clear_reports();
    hold(1'b1, 40);
    hold(1'b0, 60);
    vectors++; if (TIMEOUT !== 1'b0) begin miscompares++;
      $display("FAIL tmo_clear got %b want 0", TIMEOUT); end
    vectors++; if (rep_q.size() !== 0) begin miscompares++;
      $display("FAIL tmo_no_valid got %0d want 0", rep_q.size()); end
    vectors++; if (State !== 2'b10) begin miscompares++;
      $display("FAIL tmo_resume_state got %b want 10", State); end
    hold(1'b1, 40);
    hold(1'b0, 60);
    vectors++; if (rep_q.size() !== 1) begin miscompares++;
      $display("FAIL tmo_next_count got %0d want 1", rep_q.size()); end
    if (rep_q.size() > 0) begin
      vectors++; if (rep_q[0] !== {32'd100, 32'd40}) begin miscompares++;
        $display("FAIL tmo_next_report got %0d/%0d want 100/40", rep_q[0].per, rep_q[0].ht); end
    end
  endtask

  // Period exactly at the limit: edge wins, report 1000, no timeout.
  task automatic test_coincident();
    clear_reports();
    hold(1'b1, 500);
    hold(1'b0, 500);
    hold(1'b1, 10);
    vectors++; if (rep_q.size() !== 2) begin miscompares++;
      $display("FAIL coin_count got %0d want 2", rep_q.size()); end
    if (rep_q.size() > 1) begin
      vectors++; if (rep_q[0] !== {32'd100, 32'd40}) begin miscompares++;
        $display("FAIL coin_first got %0d/%0d want 100/40", rep_q[0].per, rep_q[0].ht); end
      vectors++; if (rep_q[1] !== {32'd1000, 32'd500}) begin miscompares++;
        $display("FAIL coin_report got %0d/%0d want 1000/500", rep_q[1].per, rep_q[1].ht); end
    end
    vectors++; if (TIMEOUT !== 1'b0) begin miscompares++;
      $display("FAIL coin_timeout got %b want 0", TIMEOUT); end
    vectors++; if (State !== 2'b01) begin miscompares++;
      $display("FAIL coin_state got %b want 01", State); end
  endtask

  // Reset pulse while in LOW.
  task automatic test_reset_mid();
    hold(1'b1, 30);
    hold(1'b0, 20);
    vectors++; if (State !== 2'b10) begin miscompares++;
      $display("FAIL rmid_pre_state got %b want 10", State); end
    clear_reports();
    RST = 1'b1;
    @(posedge CLK_IN);
    @(negedge CLK_IN);
    vectors++; if (State !== 2'b00 || PERIOD !== 32'd0 || HIGH_TIME !== 32'd0 ||
                   VALID !== 1'b0 || TIMEOUT !== 1'b0) begin miscompares++;
      $display("FAIL rmid_outputs got st=%b per=%0d ht=%0d v=%b to=%b want all zero",
               State, PERIOD, HIGH_TIME, VALID, TIMEOUT); end
    RST = 1'b0;
    @(posedge CLK_IN);
    #1;
    for (int i = 0; i < 3; i++) begin
      hold(1'b1, 40);
      hold(1'b0, 60);
    end
    vectors++; if (rep_q.size() !== 2) begin miscompares++;
      $display("FAIL rmid_count got %0d want 2", rep_q.size()); end
    for (int i = 0; i < rep_q.size(); i++) begin
      vectors++; if (rep_q[i] !== {32'd100, 32'd40}) begin miscompares++;
        $display("FAIL rmid_report[%0d] got %0d/%0d want 100/40", i, rep_q[i].per, rep_q[i].ht); end
    end
  endtask

  // EN low for 500 cycles while the input keeps toggling.
  task automatic test_en_drop();
    hold(1'b1, 40);
    hold(1'b0, 30);
    EN = 1'b0;
    clear_reports();
    hold(1'b0, 30);
    for (int i = 0; i < 4; i++) begin
      hold(1'b1, 40);
      hold(1'b0, 60);
    end
    hold(1'b1, 40);
    hold(1'b0, 30);
    vectors++; if (State !== 2'b00) begin miscompares++;
      $display("FAIL en_state got %b want 00", State); end
    vectors++; if (PERIOD !== 32'd100 || HIGH_TIME !== 32'd40) begin miscompares++;
      $display("FAIL en_hold got %0d/%0d want 100/40", PERIOD, HIGH_TIME); end
    vectors++; if (rep_q.size() !== 0) begin miscompares++;
      $display("FAIL en_no_valid got %0d want 0", rep_q.size()); end
    EN = 1'b1;
    hold(1'b0, 30);
    rise_cyc = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) rise_cyc = cyc;
      hold(1'b1, 40);
      hold(1'b0, 60);
    end
    vectors++; if (rep_q.size() !== 2) begin miscompares++;
      $display("FAIL en_count got %0d want 2", rep_q.size()); end
    if (rep_q.size() > 0) begin
      vectors++; if (rep_cyc[0] !== rise_cyc + 4) begin miscompares++;
        $display("FAIL en_first_cycle got %0d want %0d", rep_cyc[0], rise_cyc + 4); end
      vectors++; if (rep_q[0] !== {32'd100, 32'd40}) begin miscompares++;
        $display("FAIL en_report got %0d/%0d want 100/40", rep_q[0].per, rep_q[0].ht); end
    end
  endtask

  task automatic test_back_to_back();
    vectors++; if (dbl_valid !== 1'b0) begin miscompares++;
      $display("FAIL valid_consecutive got %b want 0", dbl_valid); end
  endtask

  initial begin
    test_reset();
    @(posedge CLK_IN);
    #1;
    test_basic();
    test_period_change();
    test_timeout();
    test_coincident();
    test_reset_mid();
    test_en_drop();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
